// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage that feeds the IF_ID register. It owns the program
// counter and reads a synchronous instruction memory with a one-cycle read
// latency. Fetched words go into a small in-order queue, so a stall from ID
// never loses a read that is already in flight. A taken branch from MEM
// redirects the PC and flushes every older fetch.
//
// Parameters
//   RESET_PC  PC loaded on reset (word address)
//   PC_INC    PC increment per instruction
//   DEPTH     queue entries (>= 2); the credit count includes the in-flight read
//
// Ports
//   clk             in   rising-edge clock for all state
//   reset           in   asynchronous, active-high; clears all state
//   imem_en         out  instruction memory read strobe (combinational)
//   imem_addr       out  instruction memory read address (= fetch PC)
//   imem_rdata      in   read data, valid the cycle after imem_en
//   branch_taken    in   redirect request from MEM
//   branch_target   in   redirect PC
//   ready_in        in   IF_ID accepts the head this cycle
//   valid_out       out  queue head valid
//   instruction_IF  out  queue head instruction
//   PC_sumado_IF    out  queue head PC + PC_INC
//   occupancy       out  entries held in the queue (excludes in-flight read)
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_INC   = 32'd1,
    parameter int          DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_en,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [31:0]                instruction_IF,
    output logic [31:0]                PC_sumado_IF,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    // Architectural state
    logic [31:0]   fetch_pc_r;
    logic [31:0]   tag_pc_r;
    logic          inflight_r;
    logic          discard_r;
    logic          valid_r;
    logic [CW-1:0] count_r;
    logic [31:0]   q_instr_r [DEPTH];
    logic [31:0]   q_pcs_r   [DEPTH];

    // Next-state / control signals
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   credit_s;
    logic [CW-1:0] count_s;
    logic [31:0]   q_instr_s [DEPTH];
    logic [31:0]   q_pcs_s   [DEPTH];

    // Outputs come straight from state; the head is always entry 0.
    assign valid_out      = valid_r;
    assign instruction_IF = q_instr_r[0];
    assign PC_sumado_IF   = q_pcs_r[0];
    assign occupancy      = count_r;
    assign imem_en        = issue_s;
    assign imem_addr      = fetch_pc_r;

    // Handshake, credit check and read issue decision
    always_comb begin
        pop_s  = valid_r & ready_in;
        // A returning word is accepted only if it has not been cancelled by a
        // redirect, either this cycle or when it was issued.
        push_s = inflight_r & ~discard_r & ~branch_taken;
        // Queue entries plus the in-flight read, minus the slot freed by this
        // cycle's pop; pop implies count_r >= 1 so this never underflows.
        credit_s = {1'b0, count_r}
                 + {{CW{1'b0}}, inflight_r}
                 - {{CW{1'b0}}, pop_s};
        if (credit_s < DEPTH_C) begin
            issue_s = ~reset & ~branch_taken;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Queue next state: shift-register FIFO, head at index 0
    always_comb begin
        q_instr_s = q_instr_r;
        q_pcs_s   = q_pcs_r;
        count_s   = count_r;
        if (branch_taken) begin
            // Redirect overrides pop and push: everything queued is older
            // than the branch and must be discarded.
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_s[i] = 32'd0;
                q_pcs_s[i]   = 32'd0;
            end
            count_s = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_instr_s[i] = q_instr_r[i + 1];
                    q_pcs_s[i]   = q_pcs_r[i + 1];
                end
                q_instr_s[DEPTH - 1] = 32'd0;
                q_pcs_s[DEPTH - 1]   = 32'd0;
                count_s = count_r - CW'(1);
            end else begin
                count_s = count_r;
            end
            if (push_s) begin
                // Append behind whatever remains after the pop; the credit
                // rule guarantees a free slot here.
                for (int i = 0; i < DEPTH; i++) begin
                    if (count_s == CW'(i)) begin
                        q_instr_s[i] = imem_rdata;
                        q_pcs_s[i]   = tag_pc_r;
                    end else begin
                        q_instr_s[i] = q_instr_s[i];
                        q_pcs_s[i]   = q_pcs_s[i];
                    end
                end
                count_s = count_s + CW'(1);
            end else begin
                count_s = count_s;
            end
        end
    end

    // PC, in-flight tracking and registered output state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            tag_pc_r   <= 32'd0;
            inflight_r <= 1'b0;
            discard_r  <= 1'b0;
            valid_r    <= 1'b0;
            count_r    <= {CW{1'b0}};
        end else begin
            if (branch_taken) begin
                fetch_pc_r <= branch_target;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PC_INC;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            inflight_r <= issue_s;

            if (issue_s) begin
                tag_pc_r <= fetch_pc_r + PC_INC;
            end else begin
                tag_pc_r <= tag_pc_r;
            end

            // Guard: a read that will land next cycle behind a redirect is
            // marked stale; the mark clears once that read has landed.
            if (branch_taken && issue_s) begin
                discard_r <= 1'b1;
            end else if (inflight_r) begin
                discard_r <= 1'b0;
            end else begin
                discard_r <= discard_r;
            end

            valid_r <= (count_s != {CW{1'b0}});
            count_r <= count_s;
        end
    end

    // Queue storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_r[i] <= 32'd0;
                q_pcs_r[i]   <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_r[i] <= q_instr_s[i];
                q_pcs_r[i]   <= q_pcs_s[i];
            end
        end
    end

endmodule
